// File: rtl/medidor_ciclo_trabajo.sv
// PWM duty-cycle decoder: times high phase and period between rising edges, then
// divides to a 4-bit step. Optional 3-sample glitch filter: MEDIDOR_FILTRO_GLITCH_EN.
module medidor_ciclo_trabajo #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 50000,
  parameter int MIN_PERIOD = 8
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       pwm_in,
  input  logic       habilitar,
  output logic [3:0] ciclo_medido,
  output logic       dato_valido,
  output logic       sin_senal,
  output logic       error_periodo,
  output logic [1:0] estado_dbg
);
  // dato_valido is a one-cycle strobe with no back-pressure: a consumer must
  // sample ciclo_medido/sin_senal/error_periodo in the cycle it is high.
  localparam int NUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_UNO   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, DIVIDE = 2'd2} estado_t;
  estado_t estado, estado_n;

  logic [1:0] sync_q;
  logic       s, s_d, e;

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], pwm_in};
  end

`ifdef MEDIDOR_FILTRO_GLITCH_EN
  logic [1:0] filt_h;
  logic       filt_q;
  logic [2:0] filt_win;
  assign filt_win = {filt_h, sync_q[1]};
  // Level follows only a window of three equal samples, otherwise holds.
  assign s = (filt_win == 3'b111) ? 1'b1 : (filt_win == 3'b000) ? 1'b0 : filt_q;

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      filt_h <= '0;
      filt_q <= 1'b0;
    end else begin
      filt_h <= {filt_h[0], sync_q[1]};
      filt_q <= s;
    end
  end
`else
  assign s = sync_q[1];
`endif

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) s_d <= 1'b0;
    else      s_d <= s;
  end
  assign e = s & ~s_d;

  logic [CNT_W-1:0] per_cnt, alto_cnt, pend_per, pend_alto, src_per, src_alto;
  logic             pend, armado;
  logic [NUM_W-1:0] div_rem, div_sh;
  logic [4:0]       div_q, q_step;
  logic [2:0]       div_paso;
  logic             do_timeout, do_error, do_load, do_done, pend_set, pend_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_UNO;
  endfunction

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) estado <= IDLE;
    else      estado <= estado_n;
  end

  always_comb begin
    estado_n   = estado;
    do_timeout = 1'b0;
    do_error   = 1'b0;
    do_load    = 1'b0;
    do_done    = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    // An older pending capture is served before a fresh edge.
    src_per    = pend ? pend_per : per_cnt;
    src_alto   = pend ? pend_alto : alto_cnt;
    q_step     = {div_q[3:0], (div_rem >= div_sh)};
    if (!habilitar) begin
      estado_n = IDLE;
    end else begin
      unique case (estado)
        IDLE: begin
          if (e) estado_n = MEASURE;
          else if (armado && per_cnt == TIMEOUT_C) do_timeout = 1'b1;
        end
        MEASURE: begin
          if (pend || e) begin
            pend_set = pend & e;
            pend_clr = pend & ~e;
            if (src_per < MIN_C) do_error = 1'b1;
            else begin
              do_load  = 1'b1;
              estado_n = DIVIDE;
            end
          end else if (per_cnt == TIMEOUT_C) begin
            do_timeout = 1'b1;
            estado_n   = IDLE;
          end
        end
        DIVIDE: begin
          pend_set = e;
          if (!e && per_cnt == TIMEOUT_C) begin
            do_timeout = 1'b1;
            estado_n   = IDLE;
          end else if (div_paso == 3'd4) begin
            do_done  = 1'b1;
            estado_n = MEASURE;
          end
        end
        default: estado_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      per_cnt       <= '0;
      alto_cnt      <= '0;
      pend_per      <= '0;
      pend_alto     <= '0;
      pend          <= 1'b0;
      armado        <= 1'b1;
      div_rem       <= '0;
      div_sh        <= '0;
      div_q         <= '0;
      div_paso      <= '0;
      ciclo_medido  <= 4'd0;
      dato_valido   <= 1'b0;
      sin_senal     <= 1'b1;
      error_periodo <= 1'b0;
    end else begin
      dato_valido <= 1'b0;
      if (!habilitar) begin
        per_cnt  <= '0;
        alto_cnt <= '0;
        pend     <= 1'b0;
        armado   <= 1'b1;
      end else begin
        if (e) begin
          per_cnt  <= CNT_UNO;
          alto_cnt <= CNT_UNO;
        end else if (estado == IDLE) begin
          // Idle doubles as the post-reset/enable no-signal timer while armed.
          per_cnt  <= (armado && !do_timeout) ? sat_inc(per_cnt) : '0;
          alto_cnt <= '0;
        end else begin
          per_cnt <= sat_inc(per_cnt);
          if (s) alto_cnt <= sat_inc(alto_cnt);
        end
        if (e || do_timeout) armado <= 1'b0;
        if (do_timeout) pend <= 1'b0;
        else if (pend_set) begin
          pend      <= 1'b1;
          pend_per  <= per_cnt;
          pend_alto <= alto_cnt;
        end else if (pend_clr) pend <= 1'b0;
      end

      // Restoring division of (alto*16 + per/2) by per, one quotient bit per cycle.
      if (do_load) begin
        div_rem  <= {1'b0, src_alto, 4'b0000} + {6'b000000, src_per[CNT_W-1:1]};
        div_sh   <= {1'b0, src_per, 4'b0000};
        div_q    <= '0;
        div_paso <= '0;
      end else if (estado == DIVIDE) begin
        if (div_rem >= div_sh) div_rem <= div_rem - div_sh;
        div_q    <= q_step;
        div_sh   <= div_sh >> 1;
        div_paso <= div_paso + 3'd1;
      end

      if (do_done) begin
        ciclo_medido  <= q_step[4] ? 4'hF : q_step[3:0];
        error_periodo <= 1'b0;
        sin_senal     <= 1'b0;
        dato_valido   <= 1'b1;
      end
      if (do_error) begin
        error_periodo <= 1'b1;
        dato_valido   <= 1'b1;
      end
      if (do_timeout) begin
        sin_senal    <= 1'b1;
        ciclo_medido <= {4{s}};
        dato_valido  <= 1'b1;
      end
    end
  end

  assign estado_dbg = estado;

endmodule

// File: tb/tb_medidor_ciclo_trabajo.sv
// Bench for medidor_ciclo_trabajo: plays PWM segments and compares every
// dato_valido result against a duty-rounding model of the waveform.
module tb_medidor_ciclo_trabajo;
  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 1000;
  localparam int MIN_PERIOD = 8;
`ifdef MEDIDOR_FILTRO_GLITCH_EN
  localparam int MIN_PH  = 3;
  localparam int SHORT_P = 6;
  localparam int SHORT_H = 3;
`else
  localparam int MIN_PH  = 1;
  localparam int SHORT_P = 5;
  localparam int SHORT_H = 2;
`endif

  logic       clk_100MHz = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b0;
  logic       habilitar = 1'b0;
  logic [3:0] ciclo_medido;
  logic       dato_valido, sin_senal, error_periodo;
  logic [1:0] estado_dbg;

  medidor_ciclo_trabajo #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MIN_PERIOD(MIN_PERIOD)) dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .pwm_in(pwm_in), .habilitar(habilitar),
    .ciclo_medido(ciclo_medido), .dato_valido(dato_valido), .sin_senal(sin_senal),
    .error_periodo(error_periodo), .estado_dbg(estado_dbg)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int  m_ciclo, prev_p, prev_h;
  bit  m_sin, m_err, m_armed;

  always @(negedge clk_100MHz)
    if (rst && dato_valido) obs_q.push_back({error_periodo, sin_senal, ciclo_medido});

  task automatic model_result(input int p, input int h);
    int q;
    if (p < MIN_PERIOD) m_err = 1'b1;
    else begin
      q = (32 * h + p) / (2 * p);
      m_ciclo = (q > 15) ? 15 : q;
      m_err = 1'b0;
      m_sin = 1'b0;
    end
    exp_q.push_back({m_err, m_sin, 4'(m_ciclo)});
  endtask

  task automatic model_seg(input int p, input int h);
    if (m_armed) model_result(prev_p, prev_h);
    prev_p = p;
    prev_h = h;
    m_armed = 1'b1;
  endtask

  task automatic model_timeout(input bit lvl);
    m_sin = 1'b1;
    m_ciclo = lvl ? 15 : 0;
    exp_q.push_back({m_err, m_sin, 4'(m_ciclo)});
    m_armed = 1'b0;
  endtask

  // One PWM period starting with a rising edge; g>0 adds a 1-cycle high glitch at offset g.
  task automatic play(input int p, input int h, input int g);
`ifdef MEDIDOR_FILTRO_GLITCH_EN
    model_seg(p, h);
`else
    if (g > 0) begin
      model_seg(g, h);
      model_seg(p - g, 1);
    end else model_seg(p, h);
`endif
    for (int k = 0; k < p; k++) begin
      pwm_in = (k < h) || (g > 0 && k == g);
      @(posedge clk_100MHz); #1;
    end
  endtask

  task automatic hold(input bit lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic rearm();
    habilitar = 1'b0;
    m_armed = 1'b0;
    repeat (4) @(posedge clk_100MHz);
    #1;
    habilitar = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; habilitar = 1'b0; pwm_in = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1;
    n_total++; if (ciclo_medido !== 4'd0) $display("FAIL reset_ciclo got %0d exp 0", ciclo_medido); else n_pass++;
    n_total++; if (dato_valido !== 1'b0) $display("FAIL reset_dv got %0b exp 0", dato_valido); else n_pass++;
    n_total++; if (sin_senal !== 1'b1) $display("FAIL reset_sin got %0b exp 1", sin_senal); else n_pass++;
    n_total++; if (error_periodo !== 1'b0) $display("FAIL reset_err got %0b exp 0", error_periodo); else n_pass++;
    m_ciclo = 0; m_sin = 1'b1; m_err = 1'b0; m_armed = 1'b0;
    rst = 1'b1; habilitar = 1'b1;
    repeat (5) @(posedge clk_100MHz);
    #1;
    n_total++; if (dato_valido !== 1'b0) $display("FAIL post_reset_dv got %0b exp 0", dato_valido); else n_pass++;
  endtask

  task automatic test_basic();
    rearm();
    repeat (4) play(100, 50, 0);
    repeat (20) @(posedge clk_100MHz);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) $display("FAIL basic_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (sin_senal !== 1'b0) $display("FAIL basic_sin got %0b exp 0", sin_senal); else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_steps();
    rearm();
    play(100, 25, 0); play(100, 97, 0); play(100, 3, 0); play(100, 50, 0);
    repeat (20) @(posedge clk_100MHz);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL steps_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) $display("FAIL steps_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int p, h;
    rearm();
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(99) < 20) p = $urandom_range(7, SHORT_P - 1);
      else p = $urandom_range(200, 8);
      h = $urandom_range(p - MIN_PH, MIN_PH);
      play(p, h, 0);
    end
    repeat (20) @(posedge clk_100MHz);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL random_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) $display("FAIL random_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    rearm();
    hold(1'b0, TIMEOUT + 20);
    model_timeout(1'b0);
    repeat (3) play(100, 50, 0);
    hold(1'b0, TIMEOUT + 30);
    model_timeout(1'b0);
    n_total++; if (sin_senal !== 1'b1) $display("FAIL timeout_low_sin got %0b exp 1", sin_senal); else n_pass++;
    n_total++; if (ciclo_medido !== 4'd0) $display("FAIL timeout_low_ciclo got %0d exp 0", ciclo_medido); else n_pass++;
    hold(1'b1, TIMEOUT + 30);
    model_timeout(1'b1);
    n_total++; if (ciclo_medido !== 4'd15) $display("FAIL timeout_high_ciclo got %0d exp 15", ciclo_medido); else n_pass++;
    hold(1'b0, 10);
    repeat (3) play(100, 50, 0);
    repeat (20) @(posedge clk_100MHz);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL timeout_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) $display("FAIL timeout_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (sin_senal !== 1'b0) $display("FAIL timeout_restart_sin got %0b exp 0", sin_senal); else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_error_period();
    rearm();
    repeat (2) play(100, 50, 0);
    repeat (4) play(SHORT_P, SHORT_H, 0);
    repeat (2) play(100, 75, 0);
    repeat (20) @(posedge clk_100MHz);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL error_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) $display("FAIL error_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (error_periodo !== 1'b0) $display("FAIL error_clear got %0b exp 0", error_periodo); else n_pass++;
    n_total++; if (ciclo_medido !== 4'd12) $display("FAIL error_recover got %0d exp 12", ciclo_medido); else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_divide();
    rearm();
    repeat (3) play(100, 50, 0);
    // This edge starts a division that the reset below aborts, so no result is modelled.
    for (int k = 0; k < 6; k++) begin
      pwm_in = 1'b1;
      @(posedge clk_100MHz); #1;
    end
    rst = 1'b0;
    #1;
    n_total++; if (ciclo_medido !== 4'd0) $display("FAIL rstdiv_ciclo got %0d exp 0", ciclo_medido); else n_pass++;
    n_total++; if (dato_valido !== 1'b0) $display("FAIL rstdiv_dv got %0b exp 0", dato_valido); else n_pass++;
    n_total++; if (sin_senal !== 1'b1) $display("FAIL rstdiv_sin got %0b exp 1", sin_senal); else n_pass++;
    n_total++; if (error_periodo !== 1'b0) $display("FAIL rstdiv_err got %0b exp 0", error_periodo); else n_pass++;
    exp_q.delete();
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, 1'b0, 4'd8});
    m_ciclo = 0; m_sin = 1'b1; m_err = 1'b0; m_armed = 1'b0;
    for (int k = 6; k < 100; k++) begin
      pwm_in = (k < 50);
      if (k == 70) rst = 1'b1;
      @(posedge clk_100MHz); #1;
    end
    repeat (3) play(100, 50, 0);
    repeat (20) @(posedge clk_100MHz);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rstdiv_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) $display("FAIL rstdiv_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    rearm();
    play(100, 50, 0); play(100, 50, 75); play(100, 50, 75);
    play(100, 50, 0); play(100, 50, 0);
    repeat (20) @(posedge clk_100MHz);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL glitch_count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) $display("FAIL glitch_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_steps();
    test_random();
    test_timeout();
    test_error_period();
    test_reset_divide();
    test_glitch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
